// File: rtl/red_pitaya_pwm_pkg.sv
// Shared constants, config word layout and threshold helper for the
// four-channel dithered PWM DAC.
package red_pitaya_pwm_pkg;

    localparam int PWM_FULL_DEF = 156;
    localparam int PWM_CW       = 24;
    localparam int PWM_PAT_W    = 16;
    localparam int PWM_FRM_W    = 4;

    localparam int DUTY_MSB = 23;
    localparam int DUTY_LSB = 16;
    localparam int PAT_MSB  = 15;

    typedef logic [PWM_CW-1:0] pwm_cfg_t;

    // Nine bits so duty=255 plus a dither bit cannot wrap back to zero.
    function automatic logic [8:0] pwm_thr(input logic [7:0] duty, input logic dither);
        return {1'b0, duty} + {8'd0, dither};
    endfunction

endpackage

// File: rtl/red_pitaya_pwm_dac_if.sv
// Configuration words in, PWM outputs and frame strobe out.
interface red_pitaya_pwm_dac_if;
    import red_pitaya_pwm_pkg::*;

    pwm_cfg_t   cfg_a_i;
    pwm_cfg_t   cfg_b_i;
    pwm_cfg_t   cfg_c_i;
    pwm_cfg_t   cfg_d_i;
    logic [3:0] pwm_o;
    logic       frame_o;

    modport master (
        output cfg_a_i, cfg_b_i, cfg_c_i, cfg_d_i,
        input  pwm_o, frame_o
    );

    modport slave (
        input  cfg_a_i, cfg_b_i, cfg_c_i, cfg_d_i,
        output pwm_o, frame_o
    );

endinterface

// File: rtl/red_pitaya_pwm_ch.sv
// One PWM channel: shadowed duty/dither pattern, per-period threshold and
// the registered output compare against the shared period counter.
module red_pitaya_pwm_ch
    import red_pitaya_pwm_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  pwm_cfg_t   cfg_i,
    input  logic       wrap_i,
    input  logic       boundary_i,
    input  logic [7:0] cnt_i,
    output logic       pwm_o
);

    logic [7:0]           duty_q, duty_d;
    logic [PWM_PAT_W-1:0] pat_q, pat_d;
    logic                 pwm_q, pwm_d;
    logic [8:0]           thr;

    // The pattern LSB is the dither bit for the current period, so rotating
    // at every wrap walks bit i into period i of the frame.
    always_comb begin
        duty_d = duty_q;
        pat_d  = pat_q;
        if (boundary_i) begin
            duty_d = cfg_i[DUTY_MSB:DUTY_LSB];
            pat_d  = cfg_i[PAT_MSB:0];
        end else if (wrap_i) begin
            pat_d = {pat_q[0], pat_q[PWM_PAT_W-1:1]};
        end
        thr   = pwm_thr(duty_q, pat_q[0]);
        pwm_d = ({1'b0, cnt_i} < thr);
    end

    // Reset loads the live config so the first frame already uses it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            duty_q <= cfg_i[DUTY_MSB:DUTY_LSB];
            pat_q  <= cfg_i[PAT_MSB:0];
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pat_q  <= pat_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/red_pitaya_pwm_dac.sv
// Four-channel PWM DAC: shared period/frame counters and boundary decode
// feeding four independent dithered PWM channels.
module red_pitaya_pwm_dac
    import red_pitaya_pwm_pkg::*;
#(
    parameter int FULL = PWM_FULL_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    red_pitaya_pwm_dac_if.slave  bus
);

    logic [7:0]           cnt_q, cnt_d;
    logic [PWM_FRM_W-1:0] frm_q, frm_d;
    logic                 frame_q, frame_d;
    logic                 wrap;
    logic                 boundary;
    pwm_cfg_t             cfg [4];
    logic [3:0]           pwm;

    always_comb begin
        wrap     = (cnt_q == 8'(FULL - 1));
        boundary = wrap && (frm_q == {PWM_FRM_W{1'b1}});
        cnt_d    = wrap ? 8'd0 : cnt_q + 8'd1;
        frm_d    = wrap ? frm_q + {{(PWM_FRM_W-1){1'b0}}, 1'b1} : frm_q;
        frame_d  = boundary;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= 8'd0;
            frm_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            frm_q   <= frm_d;
            frame_q <= frame_d;
        end
    end

    assign cfg[0] = bus.cfg_a_i;
    assign cfg[1] = bus.cfg_b_i;
    assign cfg[2] = bus.cfg_c_i;
    assign cfg[3] = bus.cfg_d_i;

    for (genvar ch = 0; ch < 4; ch++) begin : g_ch
        red_pitaya_pwm_ch u_ch (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .cfg_i      (cfg[ch]),
            .wrap_i     (wrap),
            .boundary_i (boundary),
            .cnt_i      (cnt_q),
            .pwm_o      (pwm[ch])
        );
    end

    assign bus.pwm_o   = pwm;
    assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_red_pitaya_pwm_dac.sv
// Scoreboard bench for red_pitaya_pwm_dac: a frame/period arithmetic model
// predicts every output cycle; a negedge monitor compares against the DUT.
module tb_red_pitaya_pwm_dac;
    import red_pitaya_pwm_pkg::*;

    localparam int FULL  = 156;
    localparam int FRAME = FULL * 16;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    pwm_cfg_t cfg_drv [4];

    red_pitaya_pwm_dac_if pwm_if ();

    assign pwm_if.cfg_a_i = cfg_drv[0];
    assign pwm_if.cfg_b_i = cfg_drv[1];
    assign pwm_if.cfg_c_i = cfg_drv[2];
    assign pwm_if.cfg_d_i = cfg_drv[3];

    red_pitaya_pwm_dac #(.FULL(FULL)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (pwm_if)
    );

    always #5 clk = ~clk;

    int         compared   = 0;
    int         mismatched = 0;
    int         s_idx      = 0;
    bit         started    = 1'b0;
    pwm_cfg_t   frame_cfg [4];
    logic [4:0] exp_q [$];

    // Output after an edge reflects the state before it: position in period,
    // period within frame, and the config captured at the frame start.
    function automatic logic expect_high(input int st, input pwm_cfg_t c);
        int cnt;
        int per;
        cnt = st % FULL;
        per = (st / FULL) % 16;
        return (cnt < (int'(c[23:16]) + int'(c[per])));
    endfunction

    always @(posedge clk) begin
        logic [3:0] e;
        if (rst) begin
            s_idx   = 0;
            started = 1'b1;
            for (int ch = 0; ch < 4; ch++) frame_cfg[ch] = cfg_drv[ch];
            exp_q.push_back(5'b0);
        end else if (started) begin
            for (int ch = 0; ch < 4; ch++) e[ch] = expect_high(s_idx, frame_cfg[ch]);
            s_idx = s_idx + 1;
            if (s_idx % FRAME == 0) begin
                for (int ch = 0; ch < 4; ch++) frame_cfg[ch] = cfg_drv[ch];
            end
            exp_q.push_back({(s_idx % FRAME == 0), e});
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at t=%0t state=%0d: got %h expected %h", name, $time, s_idx, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        logic [4:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("pwm_o", {4'd0, pwm_if.pwm_o}, {4'd0, e[3:0]});
            checkOutput("frame_o", {7'd0, pwm_if.frame_o}, {7'd0, e[4]});
        end
    end

    task automatic applyStimulus(input pwm_cfg_t a, input pwm_cfg_t b, input pwm_cfg_t c, input pwm_cfg_t d);
        @(negedge clk);
        cfg_drv[0] = a;
        cfg_drv[1] = b;
        cfg_drv[2] = c;
        cfg_drv[3] = d;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Bounded wait until the current state index hits a phase.
    task automatic wait_state(input int modulus, input int target, input int budget, input string what);
        int k;
        k = 0;
        while ((s_idx % modulus) != target && k < budget) begin
            @(negedge clk);
            k++;
        end
        compared++;
        if ((s_idx % modulus) != target) begin
            mismatched++;
            $display("[TB] FAIL wait_%s: phase %0d not reached, required %0d", what, s_idx % modulus, target);
        end
    endtask

    function automatic pwm_cfg_t rand_cfg();
        logic [7:0] duty;
        logic [7:0] corner [6];
        corner = '{8'd0, 8'd1, 8'd154, 8'd155, 8'd156, 8'd255};
        if ($urandom_range(0, 1) == 0) duty = corner[$urandom_range(0, 5)];
        else                           duty = 8'($urandom);
        return {duty, 16'($urandom)};
    endfunction

    initial begin
        pwm_cfg_t keep [4];
        cfg_drv[0] = 24'h0F_0000;
        cfg_drv[1] = 24'h4E_0001;
        cfg_drv[2] = 24'h00_FFFF;
        cfg_drv[3] = 24'hFF_0000;
        rst = 1'b1;
        run_cycles(3);
        rst = 1'b0;
        $display("[TB] reset released, directed configs");
        run_cycles(2 * FRAME + 50);

        wait_state(FRAME, 5 * FULL, FRAME + 10, "period5");
        applyStimulus(24'h75_0000, 24'h4E_0001, 24'h00_0000, 24'h9B_0001);
        run_cycles(2 * FRAME + 30);

        wait_state(FULL, 80, FULL + 10, "cnt80");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] mid-period reset issued");
        run_cycles(FRAME + 200);

        // Config present only in the boundary cycle must still be captured.
        wait_state(FRAME, FRAME - 1, FRAME + 10, "boundary");
        for (int ch = 0; ch < 4; ch++) keep[ch] = cfg_drv[ch];
        cfg_drv[0] = rand_cfg();
        cfg_drv[1] = rand_cfg();
        cfg_drv[2] = rand_cfg();
        cfg_drv[3] = rand_cfg();
        applyStimulus(keep[0], keep[1], keep[2], keep[3]);
        run_cycles(FRAME + 20);

        for (int it = 0; it < 6; it++) begin
            applyStimulus(rand_cfg(), rand_cfg(), rand_cfg(), rand_cfg());
            run_cycles($urandom_range(200, 2500));
            if ($urandom_range(0, 3) == 0) pulse_reset();
        end
        run_cycles(10);

        #2;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
